// File: rtl/decoder_scan_ctrl.sv
// Select-pair sequencer for a 2x4 decoder: walks idx 0..3 at a prescaled rate,
// with hold, single-step and direct-load modes. All outputs are registered.
module decoder_scan_ctrl #(
  parameter int PRESCALE = 4,
  parameter int PS_W     = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       step,
  input  logic       load,
  input  logic [1:0] load_idx,
  output logic       a,
  output logic       b,
  output logic       tick,
  output logic       wrap,
  output logic       busy
);

  // state  | meaning
  // S_IDLE | parked, idx forced to 0, waiting for start
  // S_SCAN | idx auto-advances every PRESCALE cycles
  // S_HOLD | idx and pc frozen; step/load move idx manually
  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_HOLD} state_t;

  localparam logic [PS_W-1:0] PC_LAST = PS_W'(PRESCALE - 1);

  state_t          r_state;
  logic [1:0]      r_idx;
  logic [PS_W-1:0] r_pc;
  logic            r_tick;
  logic            r_wrap;
  logic            r_busy;
  logic            w_pc_last;

  assign w_pc_last = (r_pc == PC_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= 2'd0;
      r_pc    <= '0;
      r_tick  <= 1'b0;
      r_wrap  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && !stop) begin
            r_state <= S_SCAN;
            r_idx   <= 2'd0;
            r_pc    <= '0;
            r_tick  <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_SCAN: begin
          if (stop) begin
            r_state <= S_HOLD;
          end else if (load) begin
            r_idx  <= load_idx;
            r_pc   <= '0;
            r_tick <= 1'b1;
          end else if (w_pc_last) begin
            r_idx  <= r_idx + 2'd1;
            r_pc   <= '0;
            r_tick <= 1'b1;
            r_wrap <= (r_idx == 2'd3);
          end else begin
            r_pc <= r_pc + 1'b1;
          end
        end
        S_HOLD: begin
          if (stop) begin
            r_state <= S_IDLE;
            r_idx   <= 2'd0;
            r_pc    <= '0;
            r_busy  <= 1'b0;
          end else if (start) begin
            // resume keeps idx and the partially elapsed slot count
            r_state <= S_SCAN;
          end else if (load) begin
            r_idx  <= load_idx;
            r_pc   <= '0;
            r_tick <= 1'b1;
          end else if (step) begin
            r_idx  <= r_idx + 2'd1;
            r_tick <= 1'b1;
            r_wrap <= (r_idx == 2'd3);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_idx   <= 2'd0;
          r_pc    <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign a    = r_idx[1];
  assign b    = r_idx[0];
  assign tick = r_tick;
  assign wrap = r_wrap;
  assign busy = r_busy;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Directed bench for decoder_scan_ctrl: PRESCALE=4 instance for most modes,
// PRESCALE=1 instance for the continuous-tick case.
module tb_decoder_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, stop, step, load;
  logic [1:0] load_idx;
  logic       a0, b0, tick0, wrap0, busy0;
  logic       start1;
  logic       a1, b1, tick1, wrap1, busy1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  decoder_scan_ctrl #(.PRESCALE(4), .PS_W(16)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .step(step),
    .load(load), .load_idx(load_idx), .a(a0), .b(b0), .tick(tick0),
    .wrap(wrap0), .busy(busy0)
  );

  decoder_scan_ctrl #(.PRESCALE(1), .PS_W(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .stop(1'b0), .step(1'b0),
    .load(1'b0), .load_idx(2'd0), .a(a1), .b(b1), .tick(tick1),
    .wrap(wrap1), .busy(busy1)
  );

  // packed view: {busy, tick, wrap, idx[1:0]}
  function automatic logic [4:0] st(input logic bz, input logic tk, input logic wr, input int idx);
    return {bz, tk, wr, 2'(idx)};
  endfunction

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got busy/tick/wrap/idx=%b, want %b", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; start = 0; stop = 0; step = 0; load = 0; load_idx = 2'd0; start1 = 0;
    #3;
    chk("reset_dut4", {busy0, tick0, wrap0, a0, b0}, 5'b0);
    chk("reset_dut1", {busy1, tick1, wrap1, a1, b1}, 5'b0);
    #9 rst_n = 1'b1;
    cyc();

    // step and load ignored in IDLE
    step = 1; cyc(); step = 0;
    chk("idle_step", {busy0, tick0, wrap0, a0, b0}, st(0, 0, 0, 0));
    load = 1; load_idx = 2'd2; cyc(); load = 0;
    chk("idle_load", {busy0, tick0, wrap0, a0, b0}, st(0, 0, 0, 0));

    // auto scan: k counts edges since start
    start = 1; cyc(); start = 0;
    chk("scan_k0", {busy0, tick0, wrap0, a0, b0}, st(1, 1, 0, 0));
    for (int k = 1; k <= 25; k++) begin
      cyc();
      chk($sformatf("scan_k%0d", k), {busy0, tick0, wrap0, a0, b0},
          st(1, (k % 4) == 0, (k % 16) == 0, (k / 4) % 4));
    end

    // hold at idx 2
    stop = 1; cyc(); stop = 0;
    chk("hold_enter", {busy0, tick0, wrap0, a0, b0}, st(1, 0, 0, 2));
    for (int i = 0; i < 20; i++) cyc();
    chk("hold_20", {busy0, tick0, wrap0, a0, b0}, st(1, 0, 0, 2));
    step = 1; cyc(); step = 0;
    chk("step_3", {busy0, tick0, wrap0, a0, b0}, st(1, 1, 0, 3));
    cyc();
    chk("step_idle_cyc", {busy0, tick0, wrap0, a0, b0}, st(1, 0, 0, 3));
    step = 1; cyc(); step = 0;
    chk("step_wrap", {busy0, tick0, wrap0, a0, b0}, st(1, 1, 1, 0));
    stop = 1; cyc(); stop = 0;
    chk("hold_to_idle", {busy0, a0, b0}, 3'b000);

    // load mid-slot: idx=1, pc=2 then load 3
    start = 1; cyc(); start = 0;
    for (int i = 0; i < 6; i++) cyc();
    chk("pre_load", {busy0, tick0, wrap0, a0, b0}, st(1, 0, 0, 1));
    load = 1; load_idx = 2'd3; cyc(); load = 0;
    chk("load_3", {busy0, tick0, wrap0, a0, b0}, st(1, 1, 0, 3));
    for (int i = 0; i < 3; i++) cyc();
    chk("load_held", {busy0, tick0, wrap0, a0, b0}, st(1, 0, 0, 3));
    cyc();
    chk("load_roll", {busy0, tick0, wrap0, a0, b0}, st(1, 1, 1, 0));

    // conflicts: start+stop in SCAN -> HOLD
    start = 1; stop = 1; cyc(); start = 0; stop = 0;
    cyc();
    chk("startstop_hold", {busy0, tick0, wrap0, a0, b0}, st(1, 0, 0, 0));
    for (int i = 0; i < 5; i++) cyc();
    chk("hold_frozen", {busy0, tick0, wrap0, a0, b0}, st(1, 0, 0, 0));
    // start+load in HOLD -> SCAN, idx kept, pc resumes from 0
    start = 1; load = 1; load_idx = 2'd2; cyc(); start = 0; load = 0;
    chk("startload", {busy0, tick0, wrap0, a0, b0}, st(1, 0, 0, 0));
    for (int i = 0; i < 3; i++) cyc();
    chk("resume_slot", {busy0, tick0, wrap0, a0, b0}, st(1, 0, 0, 0));
    cyc();
    chk("resume_adv", {busy0, tick0, wrap0, a0, b0}, st(1, 1, 0, 1));

    // asynchronous reset mid-scan, no clock edge needed
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", {busy0, tick0, wrap0, a0, b0}, 5'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(); cyc();
    chk("post_rst_idle", {busy0, tick0, wrap0, a0, b0}, 5'b0);

    // PRESCALE=1 instance
    start1 = 1; cyc(); start1 = 0;
    chk("p1_k0", {busy1, tick1, wrap1, a1, b1}, st(1, 1, 0, 0));
    for (int k = 1; k <= 8; k++) begin
      cyc();
      chk($sformatf("p1_k%0d", k), {busy1, tick1, wrap1, a1, b1},
          st(1, 1, (k % 4) == 0, k % 4));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
